regfile_wb_arbiter: RTL and testbench

Write-port arbiter for the 16-entry, 32-bit register file. Two writeback sources (req0: ALU/execute path, req1: memory/load path) share the register file's single write port. Each source hands off writes through a valid/ready handshake into a one-entry holding buffer. The arbiter drains the buffers onto a registered write port, one write per cycle, and preserves program order for writes to the same destination.

---
 rtl/regfile_wb_arbiter_if.sv | 23 ++
 rtl/regfile_wb_arbiter.sv | 70 +++++++
 tb/tb_regfile_wb_arbiter.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: writeback request handshakes, stall and registered write port
interface regfile_wb_arbiter_if #(parameter int DATA_W = 32, parameter int ADDR_W = 4);
  logic              req0_valid;
  logic              req0_ready;
  logic [ADDR_W-1:0] req0_dest;
  logic [DATA_W-1:0] req0_data;
  logic              req1_valid;
  logic              req1_ready;
  logic [ADDR_W-1:0] req1_dest;
  logic [DATA_W-1:0] req1_data;
  logic              wb_stall;
  logic              writeBackEn;
  logic [ADDR_W-1:0] Dest_wb;
  logic [DATA_W-1:0] Result_wb;
  modport master (
    output req0_valid, req0_dest, req0_data, req1_valid, req1_dest, req1_data, wb_stall,
    input  req0_ready, req1_ready, writeBackEn, Dest_wb, Result_wb
  );
  modport slave (
    input  req0_valid, req0_dest, req0_data, req1_valid, req1_dest, req1_data, wb_stall,
    output req0_ready, req1_ready, writeBackEn, Dest_wb, Result_wb
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: two-source writeback arbiter onto one registered regfile write port (WB_ARB_ROUND_ROBIN_EN selects round-robin for different-dest contention)
module regfile_wb_arbiter #(parameter int DATA_W = 32, parameter int ADDR_W = 4) (
  input logic clk,
  input logic rst,
  regfile_wb_arbiter_if.slave bus
);
  logic              full0, full1, older, g0, g1, pick1, acc0, acc1, contend, rr_pick;
  logic [ADDR_W-1:0] dest0, dest1;
  logic [DATA_W-1:0] data0, data1;
  assign bus.req0_ready = !full0 | g0;
  assign bus.req1_ready = !full1 | g1;
  assign acc0 = bus.req0_valid & bus.req0_ready;
  assign acc1 = bus.req1_valid & bus.req1_ready;
`ifdef WB_ARB_ROUND_ROBIN_EN
  logic rr;
  assign rr_pick = rr;
  // rr pointer flips after every different-dest contended grant
  always_ff @(posedge clk) begin
    if (rst) rr <= 1'b0;
    else if (contend && !bus.wb_stall) rr <= !rr;
  end
`else
  assign rr_pick = 1'b0;
`endif
  // grant selection: same dest follows age, different dest follows rr_pick
  always_comb begin
    contend = full0 & full1 & (dest0 != dest1);
    pick1 = (full0 & full1) ? (contend ? rr_pick : older) : 1'b0;
    g0 = !bus.wb_stall & full0 & !(full1 & pick1);
    g1 = !bus.wb_stall & full1 & (!full0 | pick1);
  end
  // holding buffers and age bit; a buffer loaded alone is younger than one that stays
  always_ff @(posedge clk) begin
    if (rst) begin
      full0 <= 1'b0;
      full1 <= 1'b0;
      older <= 1'b0;
      dest0 <= '0;
      dest1 <= '0;
      data0 <= '0;
      data1 <= '0;
    end else begin
      full0 <= acc0 | (full0 & !g0);
      full1 <= acc1 | (full1 & !g1);
      older <= acc1 ? 1'b0 : acc0 ? 1'b1 : older;
      if (acc0) begin
        dest0 <= bus.req0_dest;
        data0 <= bus.req0_data;
      end
      if (acc1) begin
        dest1 <= bus.req1_dest;
        data1 <= bus.req1_data;
      end
    end
  end
  // registered write port; dest/data hold when nothing is granted
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.writeBackEn <= 1'b0;
      bus.Dest_wb <= '0;
      bus.Result_wb <= '0;
    end else begin
      bus.writeBackEn <= g0 | g1;
      if (g0 | g1) begin
        bus.Dest_wb <= g1 ? dest1 : dest0;
        bus.Result_wb <= g1 ? data1 : data0;
      end
    end
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  regfile_wb_arbiter_if #(.DATA_W(32), .ADDR_W(4)) bus ();
  regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(4)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic expw(input string tag, input logic [3:0] d, input logic [31:0] r);
    check({tag, "_en"}, 32'(bus.writeBackEn), 32'd1);
    check({tag, "_dest"}, 32'(bus.Dest_wb), 32'(d));
    check({tag, "_data"}, bus.Result_wb, r);
  endtask
  task automatic idle();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
  endtask
  task automatic put0(input logic [3:0] d, input logic [31:0] r);
    bus.req0_valid = 1'b1;
    bus.req0_dest = d;
    bus.req0_data = r;
  endtask
  task automatic put1(input logic [3:0] d, input logic [31:0] r);
    bus.req1_valid = 1'b1;
    bus.req1_dest = d;
    bus.req1_data = r;
  endtask
  initial begin
    logic rr_en;
`ifdef WB_ARB_ROUND_ROBIN_EN
    rr_en = 1'b1;
`else
    rr_en = 1'b0;
`endif
    idle();
    bus.req0_dest = '0;
    bus.req0_data = '0;
    bus.req1_dest = '0;
    bus.req1_data = '0;
    bus.wb_stall = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_en", 32'(bus.writeBackEn), 32'd0);
    check("rst_dest", 32'(bus.Dest_wb), 32'd0);
    check("rst_data", bus.Result_wb, 32'd0);
    check("rst_rdy0", 32'(bus.req0_ready), 32'd1);
    check("rst_rdy1", 32'(bus.req1_ready), 32'd1);
    put0(4'd3, 32'hAA);
    tick();
    idle();
    check("lat_en_early", 32'(bus.writeBackEn), 32'd0);
    check("lat_rdy0", 32'(bus.req0_ready), 32'd1);
    tick();
    expw("lat", 4'd3, 32'hAA);
    tick();
    check("lat_en_off", 32'(bus.writeBackEn), 32'd0);
    for (int b = 0; b < 2; b++) begin
      logic first1;
      first1 = rr_en && (b == 1);
      put0(4'd5, 32'h11);
      put1(4'd6, 32'h22);
      tick();
      idle();
      tick();
      if (first1) expw("burst_a", 4'd6, 32'h22); else expw("burst_a", 4'd5, 32'h11);
      tick();
      if (first1) expw("burst_b", 4'd5, 32'h11); else expw("burst_b", 4'd6, 32'h22);
      tick();
      check("burst_off", 32'(bus.writeBackEn), 32'd0);
    end
    bus.wb_stall = 1'b1;
    put1(4'd7, 32'h1);
    tick();
    idle();
    put0(4'd7, 32'h2);
    tick();
    idle();
    check("ord_rdy0", 32'(bus.req0_ready), 32'd0);
    check("ord_rdy1", 32'(bus.req1_ready), 32'd0);
    check("ord_en_stall", 32'(bus.writeBackEn), 32'd0);
    bus.wb_stall = 1'b0;
    tick();
    expw("ord_first", 4'd7, 32'h1);
    tick();
    expw("ord_second", 4'd7, 32'h2);
    tick();
    check("ord_off", 32'(bus.writeBackEn), 32'd0);
    bus.wb_stall = 1'b1;
    put0(4'd8, 32'h33);
    put1(4'd9, 32'h44);
    tick();
    idle();
    for (int i = 0; i < 4; i++) begin
      check("stall_en", 32'(bus.writeBackEn), 32'd0);
      check("stall_rdy0", 32'(bus.req0_ready), 32'd0);
      check("stall_rdy1", 32'(bus.req1_ready), 32'd0);
      if (i < 3) tick();
    end
    bus.wb_stall = 1'b0;
    tick();
    expw("stall_a", 4'd8, 32'h33);
    tick();
    expw("stall_b", 4'd9, 32'h44);
    tick();
    check("stall_off", 32'(bus.writeBackEn), 32'd0);
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) put0(4'(i), 32'(i * 16)); else idle();
      check("stream_rdy0", 32'(bus.req0_ready), 32'd1);
      tick();
      if (i >= 1) expw("stream", 4'(i - 1), 32'((i - 1) * 16));
    end
    tick();
    check("stream_off", 32'(bus.writeBackEn), 32'd0);
    bus.wb_stall = 1'b1;
    put0(4'd10, 32'h55);
    put1(4'd11, 32'h66);
    tick();
    idle();
    check("prerst_rdy0", 32'(bus.req0_ready), 32'd0);
    check("prerst_rdy1", 32'(bus.req1_ready), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.wb_stall = 1'b0;
    check("mrst_en", 32'(bus.writeBackEn), 32'd0);
    check("mrst_dest", 32'(bus.Dest_wb), 32'd0);
    check("mrst_data", bus.Result_wb, 32'd0);
    check("mrst_rdy0", 32'(bus.req0_ready), 32'd1);
    check("mrst_rdy1", 32'(bus.req1_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mrst_drop_en", 32'(bus.writeBackEn), 32'd0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
